// File: rtl/ha_sched_pkg.sv
// Shared channel ids, display codes and the 13-entry default schedule
// for the programmable home-automation sensor scanner.
package ha_sched_pkg;

    typedef logic [2:0] ch_t;
    typedef logic [2:0] disp_t;

    localparam ch_t CH_FD   = 3'd0;
    localparam ch_t CH_RD   = 3'd1;
    localparam ch_t CH_FA   = 3'd2;
    localparam ch_t CH_W    = 3'd3;
    localparam ch_t CH_TEMP = 3'd4;
    // Ids from CH_IDLE up to 7 are idle slots.
    localparam ch_t CH_IDLE = 3'd5;

    localparam disp_t DISP_NONE = 3'd0;
    localparam disp_t DISP_FD   = 3'd1;
    localparam disp_t DISP_RD   = 3'd2;
    localparam disp_t DISP_FA   = 3'd3;
    localparam disp_t DISP_W    = 3'd4;
    localparam disp_t DISP_HEAT = 3'd5;
    localparam disp_t DISP_COOL = 3'd6;

    localparam int DEF_LEN = 13;
    localparam ch_t DEF_SCHED [DEF_LEN] = '{
        CH_FD, CH_RD, CH_FA, CH_FD, CH_W, CH_RD, CH_FD,
        CH_FA, CH_TEMP, CH_FD, CH_RD, CH_W, CH_FA
    };

    // Tables longer than the default repeat it from the start.
    function automatic ch_t default_ch(input int idx);
        logic [3:0] k;
        k = 4'(idx % DEF_LEN);
        return DEF_SCHED[k];
    endfunction

endpackage

// File: rtl/ha_temp_hyst.sv
// Heater/cooler mode registers with threshold hysteresis; modes only
// update on cycles where i_en (the TEMP-slot strobe) is high.
module ha_temp_hyst #(
    parameter int ST_W   = 7,
    parameter int T_LOW  = 50,
    parameter int T_HIGH = 70,
    parameter int HYST   = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic [ST_W-1:0] i_st,
    output logic            o_heat_nxt,
    output logic            o_cool_nxt,
    output logic            o_heater,
    output logic            o_cooler
);

    localparam int ST_MAX = (1 << ST_W) - 1;

    if (T_LOW + HYST > ST_MAX) begin : g_bad_low
        $error("ha_temp_hyst: T_LOW+HYST overflows ST_W bits");
    end
    if (T_HIGH > ST_MAX || T_HIGH < HYST) begin : g_bad_high
        $error("ha_temp_hyst: T_HIGH out of range for ST_W/HYST");
    end

    localparam logic [ST_W-1:0] C_LOW      = ST_W'(T_LOW);
    localparam logic [ST_W-1:0] C_HIGH     = ST_W'(T_HIGH);
    localparam logic [ST_W-1:0] C_HEAT_OFF = ST_W'(T_LOW + HYST);
    localparam logic [ST_W-1:0] C_COOL_OFF = ST_W'(T_HIGH - HYST);

    logic r_heater;
    logic r_cooler;
    logic w_heat;
    logic w_cool;

    // Turning one mode on always clears the other, so both can never be set.
    always_comb begin
        w_heat = r_heater;
        w_cool = r_cooler;
        if (i_st < C_LOW) begin
            w_heat = 1'b1;
            w_cool = 1'b0;
        end else if (i_st > C_HIGH) begin
            w_cool = 1'b1;
            w_heat = 1'b0;
        end else begin
            if (i_st >= C_HEAT_OFF) w_heat = 1'b0;
            if (i_st <= C_COOL_OFF) w_cool = 1'b0;
        end
    end

    always_ff @(negedge i_clk) begin
        if (i_rst) begin
            r_heater <= 1'b0;
            r_cooler <= 1'b0;
        end else if (i_en) begin
            r_heater <= w_heat;
            r_cooler <= w_cool;
        end
    end

    assign o_heat_nxt = w_heat;
    assign o_cool_nxt = w_cool;
    assign o_heater   = r_heater;
    assign o_cooler   = r_cooler;

endmodule

// File: rtl/ha_sched_scanner.sv
// Programmable sensor scanner: a slot pointer walks a writable schedule table.
// Optional build macro HA_FIRE_PREEMPT_EN makes SFA checked in every slot.
module ha_sched_scanner
    import ha_sched_pkg::*;
#(
    parameter int SLOTS  = 13,
    parameter int ST_W   = 7,
    parameter int T_LOW  = 50,
    parameter int T_HIGH = 70,
    parameter int HYST   = 2
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            SFD,
    input  logic            SRD,
    input  logic            SW,
    input  logic            SFA,
    input  logic [ST_W-1:0] ST,
    input  logic            sched_we,
    input  logic [3:0]      sched_addr,
    input  logic [2:0]      sched_data,
    input  logic            alarm_ack,
    output logic            fdoor,
    output logic            rdoor,
    output logic            winbuzz,
    output logic            alarmbuzz,
    output logic            heater,
    output logic            cooler,
    output logic [2:0]      display,
    output logic [3:0]      slot_idx
);

    if (SLOTS < 2 || SLOTS > 16) begin : g_bad_slots
        $error("ha_sched_scanner: SLOTS must be 2..16");
    end

    localparam int         IDX_W   = $clog2(SLOTS);
    localparam logic [3:0] LP_LAST = 4'(SLOTS - 1);
    localparam logic [4:0] LP_SLOTS = 5'(SLOTS);

    ch_t        r_table [SLOTS];
    logic [3:0] r_slot;
    logic       r_fdoor;
    logic       r_rdoor;
    logic       r_winbuzz;
    logic       r_alarm;
    disp_t      r_display;
    logic [3:0] r_slot_idx;

    ch_t        w_ch;
    logic       w_temp_en;
    logic       w_fire_set;
    logic       w_alarm_nxt;
    logic       w_wr_ok;
    logic [3:0] w_slot_nxt;
    logic       w_fd;
    logic       w_rd;
    logic       w_win;
    disp_t      w_disp;
    logic       w_heat_nxt;
    logic       w_cool_nxt;
    logic       w_heater;
    logic       w_cooler;

    assign w_ch       = r_table[r_slot[IDX_W-1:0]];
    assign w_temp_en  = (w_ch == CH_TEMP);
    assign w_slot_nxt = (r_slot == LP_LAST) ? 4'd0 : r_slot + 4'd1;
    assign w_wr_ok    = sched_we && ({1'b0, sched_addr} < LP_SLOTS);

`ifdef HA_FIRE_PREEMPT_EN
    assign w_fire_set = SFA;
`else
    assign w_fire_set = SFA && (w_ch == CH_FA);
`endif

    // Set has priority; ack only clears once the sensor itself has dropped.
    assign w_alarm_nxt = w_fire_set ? 1'b1 :
                         (alarm_ack && !SFA) ? 1'b0 : r_alarm;

    ha_temp_hyst #(
        .ST_W   (ST_W),
        .T_LOW  (T_LOW),
        .T_HIGH (T_HIGH),
        .HYST   (HYST)
    ) u_temp (
        .i_clk      (Clk),
        .i_rst      (Rst),
        .i_en       (w_temp_en),
        .i_st       (ST),
        .o_heat_nxt (w_heat_nxt),
        .o_cool_nxt (w_cool_nxt),
        .o_heater   (w_heater),
        .o_cooler   (w_cooler)
    );

    always_comb begin
        w_fd   = 1'b0;
        w_rd   = 1'b0;
        w_win  = 1'b0;
        w_disp = DISP_NONE;
        case (w_ch)
            CH_FD: if (SFD) begin
                w_fd   = 1'b1;
                w_disp = DISP_FD;
            end
            CH_RD: if (SRD) begin
                w_rd   = 1'b1;
                w_disp = DISP_RD;
            end
            CH_W: if (SW) begin
                w_win  = 1'b1;
                w_disp = DISP_W;
            end
            CH_FA: if (SFA) w_disp = DISP_FA;
            CH_TEMP: begin
                if (w_heat_nxt)      w_disp = DISP_HEAT;
                else if (w_cool_nxt) w_disp = DISP_COOL;
            end
            default: w_disp = DISP_NONE;
        endcase
`ifdef HA_FIRE_PREEMPT_EN
        if (SFA) w_disp = DISP_FA;
`endif
    end

    always_ff @(negedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < SLOTS; i++) r_table[i] <= default_ch(i);
            r_slot     <= 4'd0;
            r_fdoor    <= 1'b0;
            r_rdoor    <= 1'b0;
            r_winbuzz  <= 1'b0;
            r_alarm    <= 1'b0;
            r_display  <= DISP_NONE;
            r_slot_idx <= 4'd0;
        end else begin
            if (w_wr_ok) r_table[sched_addr[IDX_W-1:0]] <= sched_data;
            r_slot     <= w_slot_nxt;
            r_fdoor    <= w_fd;
            r_rdoor    <= w_rd;
            r_winbuzz  <= w_win;
            r_alarm    <= w_alarm_nxt;
            r_display  <= w_disp;
            r_slot_idx <= r_slot;
        end
    end

    assign fdoor     = r_fdoor;
    assign rdoor     = r_rdoor;
    assign winbuzz   = r_winbuzz;
    assign alarmbuzz = r_alarm;
    assign heater    = w_heater;
    assign cooler    = w_cooler;
    assign display   = r_display;
    assign slot_idx  = r_slot_idx;

endmodule

// File: tb/tb_ha_sched_scanner.sv
// Directed bench for ha_sched_scanner (default 13-slot table, falling-edge state).
module tb_ha_sched_scanner;

    localparam int SLOTS = 13;

    logic       Clk = 1'b1;
    logic       Rst;
    logic       SFD, SRD, SW, SFA;
    logic [6:0] ST;
    logic       sched_we;
    logic [3:0] sched_addr;
    logic [2:0] sched_data;
    logic       alarm_ack;
    logic       fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler;
    logic [2:0] display;
    logic [3:0] slot_idx;

    int   checks   = 0;
    int   failures = 0;
    int   pos      = 0;
    logic exp_fd;

    always #5 Clk = ~Clk;

    ha_sched_scanner dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .SFD        (SFD),
        .SRD        (SRD),
        .SW         (SW),
        .SFA        (SFA),
        .ST         (ST),
        .sched_we   (sched_we),
        .sched_addr (sched_addr),
        .sched_data (sched_data),
        .alarm_ack  (alarm_ack),
        .fdoor      (fdoor),
        .rdoor      (rdoor),
        .winbuzz    (winbuzz),
        .alarmbuzz  (alarmbuzz),
        .heater     (heater),
        .cooler     (cooler),
        .display    (display),
        .slot_idx   (slot_idx)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One active (falling) edge; pos tracks the next slot to be serviced.
    task automatic step();
        logic rs;
        rs = Rst;
        @(negedge Clk);
        #2;
        if (rs) pos = 0;
        else    pos = (pos == SLOTS - 1) ? 0 : pos + 1;
    endtask

    task automatic goto_slot(input int n);
        for (int k = 0; k < SLOTS && pos != n; k++) step();
    endtask

    initial begin
        Rst = 1'b1; SFD = 0; SRD = 0; SW = 0; SFA = 0; ST = 7'd60;
        sched_we = 0; sched_addr = 0; sched_data = 0; alarm_ack = 0;
        step(); step();
        Rst = 1'b0;
        chk("rst_fdoor",   8'(fdoor),     8'd0);
        chk("rst_rdoor",   8'(rdoor),     8'd0);
        chk("rst_win",     8'(winbuzz),   8'd0);
        chk("rst_alarm",   8'(alarmbuzz), 8'd0);
        chk("rst_heater",  8'(heater),    8'd0);
        chk("rst_cooler",  8'(cooler),    8'd0);
        chk("rst_display", 8'(display),   8'd0);
        chk("rst_slot",    8'(slot_idx),  8'd0);

        // Full lap with front door held open
        SFD = 1'b1;
        for (int s = 0; s < SLOTS; s++) begin
            exp_fd = (s == 0 || s == 3 || s == 6 || s == 9);
            step();
            chk("lap_fdoor", 8'(fdoor),    8'(exp_fd));
            chk("lap_disp",  8'(display),  exp_fd ? 8'd1 : 8'd0);
            chk("lap_slot",  8'(slot_idx), 8'(s));
        end
        SFD = 1'b0;

        // Temperature hysteresis
        ST = 7'd45; goto_slot(8); step();
        chk("t45_heater", 8'(heater), 8'd1);
        chk("t45_cooler", 8'(cooler), 8'd0);
        chk("t45_disp",   8'(display), 8'd5);
        step();
        chk("heat_held",  8'(heater), 8'd1);
        chk("heat_held_disp", 8'(display), 8'd0);
        ST = 7'd51; goto_slot(8); step();
        chk("t51_heater", 8'(heater), 8'd1);
        chk("t51_disp",   8'(display), 8'd5);
        ST = 7'd52; goto_slot(8); step();
        chk("t52_heater", 8'(heater), 8'd0);
        chk("t52_disp",   8'(display), 8'd0);
        ST = 7'd71; goto_slot(8); step();
        chk("t71_cooler", 8'(cooler), 8'd1);
        chk("t71_heater", 8'(heater), 8'd0);
        chk("t71_disp",   8'(display), 8'd6);
        ST = 7'd69; goto_slot(8); step();
        chk("t69_cooler", 8'(cooler), 8'd1);
        chk("t69_disp",   8'(display), 8'd6);
        ST = 7'd68; goto_slot(8); step();
        chk("t68_cooler", 8'(cooler), 8'd0);
        chk("t68_disp",   8'(display), 8'd0);
        ST = 7'd60;

        // Fire alarm latch and acknowledge
        goto_slot(2); SFA = 1'b1; step(); SFA = 1'b0;
        chk("fa_set",      8'(alarmbuzz), 8'd1);
        chk("fa_set_disp", 8'(display),   8'd3);
        step();
        chk("fa_hold",      8'(alarmbuzz), 8'd1);
        chk("fa_hold_disp", 8'(display),   8'd0);
        alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
        chk("fa_ack", 8'(alarmbuzz), 8'd0);
        goto_slot(7); SFA = 1'b1; alarm_ack = 1'b1; step();
        chk("fa_set_wins", 8'(alarmbuzz), 8'd1);
        chk("fa_s7_disp",  8'(display),   8'd3);
        step();
        chk("fa_ack_blocked", 8'(alarmbuzz), 8'd1);
`ifdef HA_FIRE_PREEMPT_EN
        chk("fa_s8_disp", 8'(display), 8'd3);
`else
        chk("fa_s8_disp", 8'(display), 8'd0);
`endif
        SFA = 1'b0; step(); alarm_ack = 1'b0;
        chk("fa_ack2", 8'(alarmbuzz), 8'd0);

        // SFA outside an FA slot
        goto_slot(0); SFA = 1'b1; step(); SFA = 1'b0;
`ifdef HA_FIRE_PREEMPT_EN
        chk("pre_alarm", 8'(alarmbuzz), 8'd1);
        chk("pre_disp",  8'(display),   8'd3);
`else
        chk("pre_alarm", 8'(alarmbuzz), 8'd0);
        chk("pre_disp",  8'(display),   8'd0);
`endif
        chk("pre_slot", 8'(slot_idx), 8'd0);
        alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
        chk("pre_clear", 8'(alarmbuzz), 8'd0);

        // Schedule rewrite: same-slot write uses the old entry this lap
        goto_slot(0); SFD = 1'b1; SW = 1'b1;
        sched_we = 1'b1; sched_addr = 4'd0; sched_data = 3'd3;
        step(); sched_we = 1'b0;
        chk("wr_old_fdoor", 8'(fdoor),   8'd1);
        chk("wr_old_disp",  8'(display), 8'd1);
        chk("wr_old_win",   8'(winbuzz), 8'd0);
        goto_slot(0); step();
        chk("wr_new_win",   8'(winbuzz), 8'd1);
        chk("wr_new_disp",  8'(display), 8'd4);
        chk("wr_new_fdoor", 8'(fdoor),   8'd0);
        SFD = 1'b0; SW = 1'b0; SRD = 1'b1;
        sched_we = 1'b1; sched_addr = 4'd1; sched_data = 3'd7;
        step(); sched_we = 1'b0;
        chk("wr1_old_rdoor", 8'(rdoor),   8'd1);
        chk("wr1_old_disp",  8'(display), 8'd2);
        goto_slot(1); step();
        chk("idle_rdoor", 8'(rdoor),   8'd0);
        chk("idle_disp",  8'(display), 8'd0);
        sched_we = 1'b1; sched_addr = 4'd13; sched_data = 3'd0;
        step(); sched_we = 1'b0;
        SRD = 1'b0; SW = 1'b1;
        goto_slot(0); step();
        chk("addr13_win",  8'(winbuzz), 8'd1);
        chk("addr13_disp", 8'(display), 8'd4);
        goto_slot(12); step();
        chk("wrap_last", 8'(slot_idx), 8'd12);
        step();
        chk("wrap_first", 8'(slot_idx), 8'd0);
        SW = 1'b0;

        // Mid-operation reset with heater and alarm set, table modified
        goto_slot(2); SFA = 1'b1; step(); SFA = 1'b0;
        ST = 7'd45; goto_slot(8); step();
        chk("pre_rst_heater", 8'(heater), 8'd1);
        goto_slot(6);
        chk("pre_rst_alarm", 8'(alarmbuzz), 8'd1);
        Rst = 1'b1; sched_we = 1'b1; sched_addr = 4'd0; sched_data = 3'd4;
        step();
        Rst = 1'b0; sched_we = 1'b0; ST = 7'd60;
        chk("mrst_fdoor",   8'(fdoor),     8'd0);
        chk("mrst_rdoor",   8'(rdoor),     8'd0);
        chk("mrst_win",     8'(winbuzz),   8'd0);
        chk("mrst_alarm",   8'(alarmbuzz), 8'd0);
        chk("mrst_heater",  8'(heater),    8'd0);
        chk("mrst_cooler",  8'(cooler),    8'd0);
        chk("mrst_display", 8'(display),   8'd0);
        chk("mrst_slot",    8'(slot_idx),  8'd0);
        SFD = 1'b1; SRD = 1'b1; SW = 1'b1;
        step();
        chk("def0_fdoor", 8'(fdoor),    8'd1);
        chk("def0_disp",  8'(display),  8'd1);
        chk("def0_win",   8'(winbuzz),  8'd0);
        chk("def0_slot",  8'(slot_idx), 8'd0);
        step();
        chk("def1_rdoor", 8'(rdoor),   8'd1);
        chk("def1_disp",  8'(display), 8'd2);
        SFD = 1'b0; SRD = 1'b0; SW = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
